fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the byte width of the FIFO write data.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, meaning the number of packet requesters (2..8).
REQ-003 The block SHALL have parameter PKT_SIZE, default 10, meaning the number of bytes per packet (2..255).
REQ-004 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have the following ports:
- CLK  in  1  single clock; the FIFO write clock.
- RST  in  1  asynchronous active-high reset.
- REQ  in  NUM_REQ  per-requester packet request; level-sensitive.
- DATA  in  NUM_REQ*DATA_WIDTH  per-requester current byte; requester i occupies slice i.
- ACK  out  NUM_REQ  one-hot; pulses when the current byte of the granted requester is consumed.
- GNT  out  NUM_REQ  one-hot registered grant; all zero when idle.
- FULL  in  1  FIFO full flag, synchronous to CLK.
- W_INC  out  1  FIFO write enable.
- WR_DATA  out  DATA_WIDTH  FIFO write data.
- BUSY  out  1  high while a packet is in transfer.
- PKT_DONE  out  1  one-cycle pulse on acceptance of the last byte of a packet.
- STALL_CNT  out  16  saturating count of transfer cycles blocked by FULL.

Function
REQ-006 The block SHALL implement an FSM with two states: IDLE and XFER.
REQ-007 In IDLE with any REQ bit high, the block SHALL register a one-hot GNT at the next CLK edge for the round-robin winner and enter XFER.
REQ-008 The round-robin winner SHALL be the first requester with REQ high at or after index RR_PTR, searching upward with wrap from NUM_REQ-1 to 0.
REQ-009 In IDLE, REQ=0 SHALL keep the state in IDLE, with GNT=0 and BUSY=0.
REQ-010 In XFER, W_INC SHALL equal !FULL (combinational), and WR_DATA SHALL equal the DATA slice of the granted requester.
REQ-011 In IDLE, W_INC SHALL be 0 and WR_DATA SHALL be 0.
REQ-012 ACK SHALL equal GNT AND W_INC.
- A requester advances to its next byte on each ACK.
- A requester holds DATA stable while granted and not acknowledged.
REQ-013 An 8-bit byte counter SHALL clear on entry to XFER and increment on each cycle with W_INC=1.
REQ-014 A byte accepted while the counter equals PKT_SIZE-1 SHALL cause all of the following at the next edge:
- state returns to IDLE;
- GNT clears;
- RR_PTR becomes (granted index + 1) mod NUM_REQ.
REQ-015 PKT_DONE SHALL be asserted combinationally in the cycle of that last accepted byte.
REQ-016 Deassertion of REQ by the granted requester mid-packet SHALL be ignored; the packet SHALL always complete PKT_SIZE bytes.
REQ-017 Consecutive packets SHALL be separated by exactly one IDLE cycle, so the minimum packet period is PKT_SIZE+1 cycles.
REQ-018 FULL held high in XFER SHALL stall the transfer: counter, GNT and state SHALL hold, and no byte SHALL be lost or duplicated.
REQ-019 STALL_CNT SHALL increment on each cycle where the state is XFER and FULL=1, and SHALL saturate at 16'hFFFF.
REQ-020 BUSY SHALL be high exactly when the state is XFER.

Reset
REQ-021 RST high SHALL asynchronously force all of the following, including mid-packet:
- state IDLE, GNT=0, RR_PTR=0, byte counter=0, STALL_CNT=0;
- therefore W_INC=0, ACK=0, PKT_DONE=0, BUSY=0, WR_DATA=0.
REQ-022 A packet interrupted by reset SHALL NOT be resumed.
REQ-023 After RST deasserts, the first edge with REQ pending SHALL perform arbitration starting at index 0.

Structure
REQ-024 A shared package fifo_ctrl_pkg SHALL hold:
- the FSM state type (IDLE, XFER);
- default constants for DATA_WIDTH, NUM_REQ and PKT_SIZE;
- the STALL_CNT width (16).
REQ-025 Winner selection SHALL be a separate combinational sub-module rr_picker (inputs REQ and RR_PTR; outputs a one-hot winner and a valid flag), instantiated once.

Verification
REQ-026 Scenario 1: REQ=4'b0001, FULL=0 -> GNT=0001 one edge later; 10 consecutive W_INC cycles with WR_DATA matching the bytes of requester 0; PKT_DONE on the 10th; BUSY falls.
REQ-027 Scenario 2: REQ=4'b1111 held for 4 packets -> grant order 0,1,2,3; each packet is 10 bytes; one IDLE cycle between packets; 44 cycles total.
REQ-028 Scenario 3: FULL=1 for 5 cycles after byte 3 -> W_INC=0 and ACK=0 for those cycles; counter holds at 4; STALL_CNT=5; bytes 4..9 follow with no gap after FULL falls.
REQ-029 Scenario 4: REQ=4'b0100 dropped after byte 2 -> all 10 bytes are still written, then IDLE.
REQ-030 Scenario 5: RST pulsed high mid-packet at byte 6 -> all outputs are 0 immediately; with REQ=4'b1010 after release, requester 1 is granted first.
REQ-031 Scenario 6: FULL forced high 70000 cycles in XFER -> STALL_CNT saturates at 65535 and does not wrap.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
package fifo_ctrl_pkg;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_PKT_SIZE   = 10;
  localparam int STALL_W        = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin winner select: first requester at or above rr_ptr, wrapping to 0.
module rr_picker
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               valid
);

  int idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter feeding one FIFO write port.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int PKT_SIZE   = DEF_PKT_SIZE
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] DATA,
  output logic [NUM_REQ-1:0]            ACK,
  output logic [NUM_REQ-1:0]            GNT,
  input  logic                          FULL,
  output logic                          W_INC,
  output logic [DATA_WIDTH-1:0]         WR_DATA,
  output logic                          BUSY,
  output logic                          PKT_DONE,
  output logic [STALL_W-1:0]            STALL_CNT
);

  localparam int         PTR_W = $clog2(NUM_REQ);
  localparam logic [7:0] LAST  = 8'(PKT_SIZE - 1);

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     rr_ptr, gnt_idx;
  logic [7:0]           byte_cnt;
  logic [STALL_W-1:0]   stall_cnt;
  logic [NUM_REQ-1:0]   win;
  logic                 win_vld, last_byte;

  rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req    (REQ),
    .rr_ptr (rr_ptr),
    .win    (win),
    .valid  (win_vld)
  );

  always_comb begin
    gnt_idx = '0;
    WR_DATA = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GNT[i]) begin
        gnt_idx = PTR_W'(i);
        if (state == XFER) WR_DATA = DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign BUSY      = (state == XFER);
  assign W_INC     = BUSY & ~FULL;
  assign ACK       = GNT & {NUM_REQ{W_INC}};
  assign last_byte = W_INC && (byte_cnt == LAST);
  assign PKT_DONE  = last_byte;
  assign STALL_CNT = stall_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld)   state_nxt = XFER;
      XFER:    if (last_byte) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // GNT is held for the whole packet; REQ is only looked at in IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      GNT       <= '0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      stall_cnt <= '0;
    end else if (state == IDLE) begin
      if (win_vld) begin
        GNT      <= win;
        byte_cnt <= '0;
      end
    end else begin
      if (last_byte) begin
        GNT      <= '0;
        byte_cnt <= '0;
        rr_ptr   <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end else if (W_INC) begin
        byte_cnt <= byte_cnt + 8'd1;
      end
      if (FULL && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: table of arbitration vectors plus hand sequences for stall, drop, reset, saturation.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int PS = 10;

  logic           tb_W_CLK;
  logic           RST;
  logic [NR-1:0]  REQ;
  logic [NR*DW-1:0] DATA;
  logic [NR-1:0]  ACK, GNT;
  logic           FULL, W_INC, BUSY, PKT_DONE;
  logic [DW-1:0]  WR_DATA;
  logic [15:0]    STALL_CNT;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .PKT_SIZE(PS)) dut (
    .CLK(tb_W_CLK), .RST(RST), .REQ(REQ), .DATA(DATA), .ACK(ACK), .GNT(GNT),
    .FULL(FULL), .W_INC(W_INC), .WR_DATA(WR_DATA), .BUSY(BUSY),
    .PKT_DONE(PKT_DONE), .STALL_CNT(STALL_CNT)
  );

  initial tb_W_CLK = 1'b0;
  always #5 tb_W_CLK = ~tb_W_CLK;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb[$];
  int            exp_pos [NR];
  logic [NR-1:0] cur_gnt;
  logic [4:0]    pos [NR];

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] exp_gnt;
  } vec_t;
  vec_t tbl [8];

  // Requester model: byte i of requester r is r*32 + i, advancing on its ACK.
  always @(posedge tb_W_CLK or posedge RST) begin
    if (RST) for (int i = 0; i < NR; i++) pos[i] <= '0;
    else     for (int i = 0; i < NR; i++) if (ACK[i]) pos[i] <= pos[i] + 5'd1;
  end

  always_comb begin
    DATA = '0;
    for (int i = 0; i < NR; i++) DATA[i*DW +: DW] = 8'(i*32) + {3'b0, pos[i]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge tb_W_CLK) begin
    if (RST === 1'b0) begin
      if (W_INC) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got byte %0h want no write", WR_DATA);
        end else begin
          logic [DW-1:0] b;
          b = sb.pop_front();
          if (WR_DATA !== b) begin
            errors++;
            $display("FAIL wr_data got %0h want %0h", WR_DATA, b);
          end
        end
      end
      chk("ack", ACK, W_INC ? cur_gnt : '0);
    end
  end

  function automatic int oh2i(input logic [NR-1:0] v);
    int r = 0;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic push_pkt(input int r);
    for (int b = 0; b < PS; b++) begin
      sb.push_back(8'(r*32 + (exp_pos[r] % 32)));
      exp_pos[r]++;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = '0; FULL = 1'b0; cur_gnt = '0;
    sb.delete();
    for (int i = 0; i < NR; i++) exp_pos[i] = 0;
    repeat (2) @(posedge tb_W_CLK);
    @(negedge tb_W_CLK); RST = 1'b0;
    #1;
    chk("rst_gnt", GNT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_winc", W_INC, 0);
    chk("rst_wrdata", WR_DATA, 0);
    chk("rst_stall", STALL_CNT, 0);
    chk("rst_done", PKT_DONE, 0);
    @(posedge tb_W_CLK); #1;
  endtask

  task automatic wait_done(input int maxc, output int n, output int wc);
    n = 0; wc = int'(W_INC);
    while (!PKT_DONE && n < maxc) begin
      @(posedge tb_W_CLK); #1;
      n++; wc += int'(W_INC);
    end
    checks++;
    if (!PKT_DONE) begin
      errors++;
      $display("FAIL pkt_done_timeout got none after %0d cycles want pulse", n);
    end
  endtask

  task automatic idle_check(input string nm);
    @(posedge tb_W_CLK); #1;
    cur_gnt = '0;
    chk({nm, "_idle_busy"}, BUSY, 0);
    chk({nm, "_idle_gnt"}, GNT, 0);
    chk({nm, "_idle_wrdata"}, WR_DATA, 0);
    chk({nm, "_sb_left"}, sb.size(), 0);
  endtask

  task automatic run_packet(input logic [NR-1:0] req, input logic [NR-1:0] exp_gnt);
    int n, wc;
    REQ = req;
    push_pkt(oh2i(exp_gnt));
    @(posedge tb_W_CLK); #1;
    chk("grant", GNT, exp_gnt);
    chk("busy", BUSY, 1);
    cur_gnt = exp_gnt;
    wait_done(40, n, wc);
    chk("pkt_len", n, PS - 1);
    chk("winc_cycles", wc, PS);
    REQ = '0;
    idle_check("pkt");
  endtask

  initial begin
    int n, wc, g, done, idles;
    logic prev_busy;
    logic [NR-1:0] order [4];

    tbl[0] = '{4'b0001, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0010};
    tbl[2] = '{4'b0011, 4'b0001};
    tbl[3] = '{4'b1000, 4'b1000};
    tbl[4] = '{4'b0110, 4'b0010};
    tbl[5] = '{4'b0100, 4'b0100};
    tbl[6] = '{4'b0101, 4'b0001};
    tbl[7] = '{4'b1001, 4'b1000};

    do_reset();
    foreach (tbl[k]) run_packet(tbl[k].req, tbl[k].exp_gnt);
    chk("tbl_stall", STALL_CNT, 0);

    // Four back-to-back packets with every requester asking.
    do_reset();
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000;
    REQ = 4'b1111;
    for (int r = 0; r < NR; r++) push_pkt(r);
    n = 0; g = 0; done = 0; idles = 0; prev_busy = 1'b0;
    while (!(done == 4 && !BUSY) && n < 80) begin
      @(posedge tb_W_CLK); #1;
      n++;
      if (BUSY && !prev_busy) begin
        if (g < 4) begin
          chk("rr_order", GNT, order[g]);
          cur_gnt = order[g];
        end
        g++;
      end
      if (!BUSY) begin
        cur_gnt = '0;
        if (done < 4) idles++;
      end
      if (PKT_DONE) begin
        done++;
        if (done == 4) REQ = '0;
      end
      prev_busy = BUSY;
    end
    cur_gnt = '0;
    chk("rr_total_cycles", n, 44);
    chk("rr_idle_gaps", idles, 3);
    chk("rr_sb_left", sb.size(), 0);

    // FULL for five cycles after four bytes.
    do_reset();
    REQ = 4'b0001; push_pkt(0);
    @(posedge tb_W_CLK); #1;
    cur_gnt = 4'b0001;
    repeat (4) begin @(posedge tb_W_CLK); #1; end
    FULL = 1'b1; #1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(posedge tb_W_CLK); #1; end
      chk("stall_winc", W_INC, 0);
      chk("stall_ack", ACK, 0);
      chk("stall_gnt", GNT, 4'b0001);
    end
    @(posedge tb_W_CLK); #1;
    FULL = 1'b0; #1;
    chk("stall_cnt5", STALL_CNT, 5);
    wait_done(40, n, wc);
    chk("stall_rest_len", n, 5);
    chk("stall_rest_winc", wc, 6);
    REQ = '0;
    idle_check("stall");

    // Granted requester drops REQ mid-packet.
    do_reset();
    REQ = 4'b0100; push_pkt(2);
    @(posedge tb_W_CLK); #1;
    chk("drop_gnt", GNT, 4'b0100);
    cur_gnt = 4'b0100;
    repeat (3) begin @(posedge tb_W_CLK); #1; end
    REQ = '0;
    wait_done(40, n, wc);
    chk("drop_len", n, 6);
    chk("drop_winc", wc, 7);
    idle_check("drop");
    idle_check("drop2");

    // Reset mid-packet, then arbitration restarts at index 0.
    do_reset();
    run_packet(4'b0010, 4'b0010);
    REQ = 4'b0100; push_pkt(2);
    @(posedge tb_W_CLK); #1;
    chk("mid_gnt", GNT, 4'b0100);
    cur_gnt = 4'b0100;
    repeat (6) begin @(posedge tb_W_CLK); #1; end
    RST = 1'b1; #1;
    chk("arst_gnt", GNT, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_winc", W_INC, 0);
    chk("arst_ack", ACK, 0);
    chk("arst_done", PKT_DONE, 0);
    chk("arst_wrdata", WR_DATA, 0);
    cur_gnt = '0;
    sb.delete();
    for (int i = 0; i < NR; i++) exp_pos[i] = 0;
    REQ = 4'b1010;
    @(posedge tb_W_CLK);
    @(negedge tb_W_CLK); RST = 1'b0;
    push_pkt(1);
    @(posedge tb_W_CLK); #1;
    chk("arst_regrant", GNT, 4'b0010);
    cur_gnt = 4'b0010;
    wait_done(40, n, wc);
    chk("arst_len", n, PS - 1);
    REQ = '0;
    idle_check("arst");

    // Long stall to saturate the counter.
    do_reset();
    REQ = 4'b1000; FULL = 1'b1; push_pkt(3);
    @(posedge tb_W_CLK); #1;
    chk("sat_gnt", GNT, 4'b1000);
    cur_gnt = 4'b1000;
    repeat (1000) @(posedge tb_W_CLK); #1;
    chk("sat_1000", STALL_CNT, 1000);
    repeat (64535) @(posedge tb_W_CLK); #1;
    chk("sat_max", STALL_CNT, 16'hFFFF);
    repeat (4465) @(posedge tb_W_CLK); #1;
    chk("sat_hold", STALL_CNT, 16'hFFFF);
    FULL = 1'b0;
    wait_done(40, n, wc);
    chk("sat_len", n, PS - 1);
    REQ = '0;
    idle_check("sat");
    chk("sat_after", STALL_CNT, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
